mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
//
// PURPOSE
// Memory-mapped responder on the RISC240 memory bus: the slave end of the datapath's memAddr/dataBus/re_L/we_L
// interface. Data-port writes are queued in a small FIFO and sent as 8N1 serial frames on txd.
// Status-port reads return queue/transmitter state on dataBus.
// Sits beside main memory in the top level, sharing memAddr, dataBus, re_L and we_L.
//
// PARAMETERS
// DATA_ADDR     16'h0610  byte address of write-only data port
// STAT_ADDR     16'h0612  byte address of status port (read = status, write = clear overflow)
// FIFO_DEPTH    4         FIFO entries; power of 2, 2..8
// CLKS_PER_BIT  434       clock cycles per serial bit, >= 2
//
// PORTS
// clock     in     1   system clock, all state on rising edge
// reset_L   in     1   asynchronous, active-low reset
// memAddr   in     16  byte address from datapath (MAR << 1)
// dataBus   inout  16  shared data bus; driven only during a status read
// re_L      in     1   active-low read enable
// we_L      in     1   active-low write enable
// txd       out    1   serial output, idle high
// busy      out    1   1 while a frame is on txd
// overflow  out    1   sticky: a data write was dropped because the FIFO was full
//
// BEHAVIOUR
// - Reset (async, reset_L=0): FIFO emptied, overflow=0, FSM=IDLE, bit counter=0, txd=1, busy=0, dataBus=Z.
//   Reset mid-frame aborts the frame at once; txd returns to 1 without a stop bit.
// - Write capture: on a clock edge with we_L=0 and memAddr==DATA_ADDR, push dataBus[7:0]
//   (dataBus[15:8] ignored). If FIFO is full and no pop occurs on the same edge, drop the byte and set overflow=1.
// - Push and pop on the same edge: both take effect and count is unchanged; a push is accepted when full if a pop happens that edge.
// - Overflow clear: on an edge with we_L=0 and memAddr==STAT_ADDR, overflow <= 0.
//   A simultaneous drop is not possible (different address), so there is no conflict.
// - Status read: combinational. When re_L=0 and memAddr==STAT_ADDR, drive
//   dataBus = {8'b0, count[3:0], overflow, empty, full, busy} (bit0=busy, bit1=full, bit2=empty, bit3=overflow, bits7:4=count).
//   In every other case dataBus=Z. Reads of DATA_ADDR are not driven.
//   The block never drives the bus while we_L=0.
// - Other addresses: ignored entirely.
// - TX FSM (tx_state_t): IDLE, START, DATA, STOP.
//   IDLE:  txd=1, busy=0. When FIFO is non-empty, pop into an 8-bit shift reg, clear the bit counter, go to START.
//   START: txd=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
//   DATA:  txd=shift[0] (LSB first). Each bit lasts CLKS_PER_BIT cycles, then shift right.
//          After bit 7 completes, go to STOP.
//   STOP:  txd=1 for CLKS_PER_BIT cycles. At the end, if FIFO is non-empty, pop and go to START (back-to-back);
//          otherwise go to IDLE.
//   busy=1 in START/DATA/STOP.
// - Latency: a write captured at edge N makes the FIFO non-empty after N. The pop happens at edge N+1,
//   and txd falls after edge N+1. A frame is exactly 10*CLKS_PER_BIT cycles.
// - Bit-time counter: clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
// - FIFO pointers: clog2(FIFO_DEPTH) bits and wrap naturally. count has clog2(FIFO_DEPTH)+1 bits, zero-extended to 4 bits.
//
// STRUCTURE
// - Shared package (constants.sv): tx_state_t enum, status-bit index localparams (ST_BUSY=0, ST_FULL=1,
//   ST_EMPTY=2, ST_OVF=3, ST_COUNT_LSB=4), DATA_ADDR/STAT_ADDR defaults.
// - Sub-module sync_fifo #(WIDTH=8, DEPTH): push/pop/din/dout/full/empty/count, async active-low reset,
//   simultaneous push and pop when full is allowed.
// - Top level: address decode, tri-state status driver (tridrive, WIDTH=16), overflow flop, TX FSM with bit-time
//   and bit-index counters.
//
// TESTING (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4)
// - Reset: assert reset_L=0 mid-frame -> txd=1, busy=0, and a status read returns 16'h0004.
// - Single byte: write 16'h1A55 to 0x0610 -> txd low 4 cycles starting 1 cycle after capture,
//   then bits 1,0,1,0,1,0,1,0 at 4 cycles each, stop high 4 cycles, busy drops after 40 cycles.
// - Back-to-back: write 8'h00 then 8'hFF on consecutive cycles -> second start bit immediately follows
//   the first stop bit, with no idle gap; total 80 cycles busy.
// - Overflow: 6 writes on consecutive cycles -> the first is popped, 4 are queued, 1 is dropped.
//   Status read shows count=4, full=1, overflow=1 (16'h004B). Writing 0x0612 clears overflow (16'h0043).
// - Bus discipline: read 0x0610, read 0x0600, and idle with re_L=1 -> dataBus stays Z.
//   Read 0x0612 with the FIFO empty and idle -> 16'h0004.
// - Full plus simultaneous pop: FIFO full while a STOP bit ends and a write arrives on the same edge ->
//   the write is accepted, count stays 4, overflow stays 0.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package mmio_uart_tx_pkg;

    localparam int unsigned BUS_W        = 16;
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned STATUS_W     = 8;
    localparam int unsigned STATUS_CNT_W = 4;
    localparam int unsigned BIT_IDX_W    = 3;

    localparam logic [BUS_W-1:0] DATA_ADDR_DEF = 16'h0610;
    localparam logic [BUS_W-1:0] STAT_ADDR_DEF = 16'h0612;

    // Status byte layout
    localparam int unsigned ST_BUSY      = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_EMPTY     = 2;
    localparam int unsigned ST_OVF       = 3;
    localparam int unsigned ST_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted when a pop happens on the same edge.
module mmio_uart_tx_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] rdata_c_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push_c;
    logic             do_pop_c;

    assign do_pop_c  = pop_i && !empty_q;
    assign do_push_c = push_i && (!full_q || do_pop_c);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push_c, do_pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign rdata_c_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign count_o   = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-bus slave: data-port writes are queued and sent as 8N1 frames on txd; status port is readable.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [BUS_W-1:0] DATA_ADDR    = DATA_ADDR_DEF,
    parameter logic [BUS_W-1:0] STAT_ADDR    = STAT_ADDR_DEF,
    parameter int unsigned      FIFO_DEPTH   = 4,
    parameter int unsigned      CLKS_PER_BIT = 434
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic [BUS_W-1:0] memAddr,
    inout  wire  [BUS_W-1:0] dataBus,
    input  logic             re_L,
    input  logic             we_L,
    output logic             txd,
    output logic             busy,
    output logic             overflow
);

    localparam int unsigned BCNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_t             state_q, state_d;
    logic [BCNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [BIT_IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0]     shift_q, shift_d;
    logic                  txd_q, txd_d;
    logic                  busy_q, busy_d;
    logic                  overflow_q, overflow_d;

    logic                  data_wr_c;
    logic                  stat_wr_c;
    logic                  stat_rd_c;
    logic                  bit_end_c;
    logic                  fifo_pop_c;
    logic [BYTE_W-1:0]     fifo_rdata_c;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FCNT_W-1:0]     fifo_count;
    logic [STATUS_W-1:0]   status_c;
    logic [BUS_W-BYTE_W-1:0] unused_bus_hi;

    // Address decode; a status read is never driven while a write is in progress
    assign data_wr_c = !we_L && (memAddr == DATA_ADDR);
    assign stat_wr_c = !we_L && (memAddr == STAT_ADDR);
    assign stat_rd_c = !re_L && we_L && (memAddr == STAT_ADDR);

    assign unused_bus_hi = dataBus[BUS_W-1:BYTE_W];

    mmio_uart_tx_sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clock),
        .rst_ni    (reset_L),
        .push_i    (data_wr_c),
        .pop_i     (fifo_pop_c),
        .din_i     (dataBus[BYTE_W-1:0]),
        .rdata_c_o (fifo_rdata_c),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    always_comb begin
        status_c                                    = '0;
        status_c[ST_BUSY]                           = busy_q;
        status_c[ST_FULL]                           = fifo_full;
        status_c[ST_EMPTY]                          = fifo_empty;
        status_c[ST_OVF]                            = overflow_q;
        status_c[ST_COUNT_LSB +: STATUS_CNT_W]      = STATUS_CNT_W'(fifo_count);
    end

    assign dataBus = stat_rd_c ? {{(BUS_W-STATUS_W){1'b0}}, status_c} : {BUS_W{1'bz}};

    // Sticky overflow: set on a dropped data write, cleared by any status-port write
    always_comb begin
        overflow_d = overflow_q;
        if (stat_wr_c) begin
            overflow_d = 1'b0;
        end else if (data_wr_c && fifo_full && !fifo_pop_c) begin
            overflow_d = 1'b1;
        end
    end

    assign bit_end_c = (bit_cnt_q == BCNT_W'(CLKS_PER_BIT - 1));

    // TX sequencer: next state, counters, pop request and registered line outputs
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        fifo_pop_c = 1'b0;

        if (state_q != TX_IDLE) begin
            bit_cnt_d = bit_end_c ? '0 : bit_cnt_q + BCNT_W'(1);
        end

        case (state_q)
            TX_IDLE: begin
                bit_cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop_c = 1'b1;
                    shift_d    = fifo_rdata_c;
                    state_d    = TX_START;
                end
            end
            TX_START: begin
                if (bit_end_c) begin
                    bit_idx_d = '0;
                    state_d   = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_end_c) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == BIT_IDX_W'(BYTE_W - 1)) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end
            end
            TX_STOP: begin
                if (bit_end_c) begin
                    if (!fifo_empty) begin
                        fifo_pop_c = 1'b1;
                        shift_d    = fifo_rdata_c;
                        state_d    = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        case (state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = shift_d[0];
            default:  txd_d = 1'b1;
        endcase
        busy_d = (state_d != TX_IDLE);
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= TX_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign txd      = txd_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: vector table for bus/FIFO behaviour plus frame-timing sequences.
module tb_mmio_uart_tx;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = 10 * CPB;

    logic        clock = 1'b0;
    logic        reset_L;
    logic [15:0] memAddr;
    logic        re_L;
    logic        we_L;
    logic        drv_en;
    logic [15:0] drv_data;
    wire  [15:0] dataBus;
    logic        txd;
    logic        busy;
    logic        overflow;

    assign dataBus = drv_en ? drv_data : 16'hzzzz;
    pullup (dataBus);

    always #5 clock = ~clock;

    mmio_uart_tx #(
        .DATA_ADDR    (16'h0610),
        .STAT_ADDR    (16'h0612),
        .FIFO_DEPTH   (4),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock    (clock),
        .reset_L  (reset_L),
        .memAddr  (memAddr),
        .dataBus  (dataBus),
        .re_L     (re_L),
        .we_L     (we_L),
        .txd      (txd),
        .busy     (busy),
        .overflow (overflow)
    );

    typedef enum int {OP_WR, OP_RD, OP_NORD, OP_WAIT} op_e;

    typedef struct {
        op_e         op;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp;
        int          n;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        memAddr  = addr;
        drv_data = data;
        drv_en   = 1'b1;
        we_L     = 1'b0;
        @(negedge clock);
        we_L     = 1'b1;
        drv_en   = 1'b0;
    endtask

    task automatic status_read(input string name, input logic [15:0] exp);
        memAddr = 16'h0612;
        re_L    = 1'b0;
        #1;
        check(name, dataBus, exp);
        re_L    = 1'b1;
    endtask

    // Expected line level at sample k (k-th negedge after the first capture edge)
    function automatic logic exp_txd(input int k, input logic [7:0] b0, input logic [7:0] b1, input int nfr);
        int p, f, seg;
        logic [7:0] b;
        if (k < 1 || k > nfr * FRAME_CYC) return 1'b1;
        f   = (k - 1) / FRAME_CYC;
        p   = (k - 1) % FRAME_CYC;
        seg = p / CPB;
        b   = (f == 0) ? b0 : b1;
        if (seg == 0) return 1'b0;
        if (seg == 9) return 1'b1;
        return b[seg-1];
    endfunction

    task automatic check_stream(input string name, input int k0, input logic [7:0] b0,
                                input logic [7:0] b1, input int nfr);
        for (int k = k0; k <= nfr * FRAME_CYC + 2; k++) begin
            check($sformatf("%s txd k=%0d", name, k), 16'(txd), 16'(exp_txd(k, b0, b1, nfr)));
            check($sformatf("%s busy k=%0d", name, k), 16'(busy),
                  16'((k >= 1 && k <= nfr * FRAME_CYC) ? 1'b1 : 1'b0));
            @(negedge clock);
        end
    endtask

    initial begin
        reset_L  = 1'b0;
        memAddr  = 16'h0000;
        re_L     = 1'b1;
        we_L     = 1'b1;
        drv_en   = 1'b0;
        drv_data = 16'h0000;

        @(negedge clock);
        @(negedge clock);
        check("reset txd", 16'(txd), 16'h0001);
        check("reset busy", 16'(busy), 16'h0000);
        check("reset overflow", 16'(overflow), 16'h0000);
        reset_L = 1'b1;
        @(negedge clock);

        // Bus discipline, ignored addresses, overflow and full-with-pop timing
        vecs.push_back('{OP_RD,   16'h0612, 16'h0000, 16'h0004, 0});
        vecs.push_back('{OP_RD,   16'h0610, 16'h0000, 16'hFFFF, 0});
        vecs.push_back('{OP_RD,   16'h0600, 16'h0000, 16'hFFFF, 0});
        vecs.push_back('{OP_NORD, 16'h0612, 16'h0000, 16'hFFFF, 0});
        vecs.push_back('{OP_WR,   16'h0600, 16'h1234, 16'h0000, 0});
        vecs.push_back('{OP_RD,   16'h0612, 16'h0000, 16'h0004, 0});
        vecs.push_back('{OP_WR,   16'h0612, 16'h0000, 16'h0000, 0});
        vecs.push_back('{OP_RD,   16'h0612, 16'h0000, 16'h0004, 0});
        vecs.push_back('{OP_WR,   16'h0610, 16'hAB11, 16'h0000, 0});
        vecs.push_back('{OP_WR,   16'h0610, 16'hAB22, 16'h0000, 0});
        vecs.push_back('{OP_WR,   16'h0610, 16'hAB33, 16'h0000, 0});
        vecs.push_back('{OP_WR,   16'h0610, 16'hAB44, 16'h0000, 0});
        vecs.push_back('{OP_WR,   16'h0610, 16'hAB55, 16'h0000, 0});
        vecs.push_back('{OP_WR,   16'h0610, 16'hAB66, 16'h0000, 0});
        vecs.push_back('{OP_RD,   16'h0612, 16'h0000, 16'h004B, 0});
        vecs.push_back('{OP_RD,   16'h0610, 16'h0000, 16'hFFFF, 0});
        vecs.push_back('{OP_WR,   16'h0612, 16'h0000, 16'h0000, 0});
        vecs.push_back('{OP_RD,   16'h0612, 16'h0000, 16'h0043, 0});
        vecs.push_back('{OP_WAIT, 16'h0000, 16'h0000, 16'h0000, 34});
        vecs.push_back('{OP_WR,   16'h0610, 16'h0077, 16'h0000, 0});
        vecs.push_back('{OP_RD,   16'h0612, 16'h0000, 16'h0043, 0});
        vecs.push_back('{OP_WAIT, 16'h0000, 16'h0000, 16'h0000, 205});
        vecs.push_back('{OP_RD,   16'h0612, 16'h0000, 16'h0004, 0});

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_WR: bus_write(vecs[i].addr, vecs[i].data);
                OP_RD: begin
                    memAddr = vecs[i].addr;
                    re_L    = 1'b0;
                    #1;
                    check($sformatf("vec%0d read %h", i, vecs[i].addr), dataBus, vecs[i].exp);
                    re_L    = 1'b1;
                end
                OP_NORD: begin
                    memAddr = vecs[i].addr;
                    re_L    = 1'b1;
                    #1;
                    check($sformatf("vec%0d idle %h", i, vecs[i].addr), dataBus, vecs[i].exp);
                end
                default: repeat (vecs[i].n) @(negedge clock);
            endcase
        end
        @(negedge clock);

        // Single frame: 0x55 -> start, 1,0,1,0,1,0,1,0, stop
        bus_write(16'h0610, 16'h1A55);
        check_stream("single", 0, 8'h55, 8'h00, 1);
        check("single overflow", 16'(overflow), 16'h0000);

        // Back-to-back frames with no idle gap
        bus_write(16'h0610, 16'h0000);
        bus_write(16'h0610, 16'h00FF);
        check_stream("b2b", 1, 8'h00, 8'hFF, 2);
        status_read("b2b status", 16'h0004);

        // Reset mid-frame with overflow set and a full FIFO
        for (int i = 0; i < 6; i++) begin
            bus_write(16'h0610, 16'h0000);
        end
        check("pre-reset overflow", 16'(overflow), 16'h0001);
        @(negedge clock);
        @(negedge clock);
        check("pre-reset txd", 16'(txd), 16'h0000);
        reset_L = 1'b0;
        #1;
        check("mid-reset txd", 16'(txd), 16'h0001);
        check("mid-reset busy", 16'(busy), 16'h0000);
        check("mid-reset overflow", 16'(overflow), 16'h0000);
        status_read("mid-reset status", 16'h0004);
        @(negedge clock);
        reset_L = 1'b1;
        repeat (3) @(negedge clock);
        check("post-reset txd", 16'(txd), 16'h0001);
        check("post-reset busy", 16'(busy), 16'h0000);
        status_read("post-reset status", 16'h0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
